// File: rtl/pin_entry.sv
// PIN entry front end: synchronises and debounces the keypad switches, assembles a
// 3-digit PIN and offers it to the validator over a valid/ready handshake.
module pin_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic       clk_2,
  input  logic       reset,
  input  logic       card_in,
  input  logic       enter_btn,
  input  logic       clear_btn,
  input  logic [2:0] code,
  input  logic       pin_ready,
  output logic       pin_valid,
  output logic [2:0] pin_d1,
  output logic [2:0] pin_d2,
  output logic [2:0] pin_d3,
  output logic [1:0] digit_count,
  output logic       reject,
  output logic       timeout,
  output logic [1:0] state_out
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_FULL    = 2'd2
  } state_e;

  state_e state, state_nxt;

  logic       card_s1, card_s;
  logic [1:0] btn_s1, btn_s;          // bit 0 enter, bit 1 clear
  logic [2:0] code_s1, code_s;

  logic [1:0]      db;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      rise_c;

  logic [TO_W-1:0] tcnt, tcnt_nxt;
  logic [2:0]      d1_nxt, d2_nxt, d3_nxt;
  logic [1:0]      dc_nxt;
  logic            reject_nxt, timeout_nxt, pin_valid_nxt;

  logic enter_press_c, clear_press_c, in_collect_c;
  logic enter_acc_c, clear_acc_c, reject_c;

  // Two-flop synchronisers for every raw switch input
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      card_s1 <= 1'b0;
      card_s  <= 1'b0;
      btn_s1  <= 2'b00;
      btn_s   <= 2'b00;
      code_s1 <= 3'd0;
      code_s  <= 3'd0;
    end else begin
      card_s1 <= card_in;
      card_s  <= card_s1;
      btn_s1  <= {clear_btn, enter_btn};
      btn_s   <= btn_s1;
      code_s1 <= code;
      code_s  <= code_s1;
    end
  end

  // Debounce: level flips after DEBOUNCE_CYCLES consecutive mismatching edges
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      db <= 2'b00;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] != db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            db[i]     <= btn_s[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_W'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  // A press is acted on the same edge the debounced level rises
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rise_c[i] = !db[i] && btn_s[i] && (db_cnt[i] == DB_LAST);
    end
  end

  assign enter_press_c = rise_c[0];
  assign clear_press_c = rise_c[1];
  assign in_collect_c  = (state == S_COLLECT);
  assign clear_acc_c   = in_collect_c && clear_press_c && (digit_count != 2'd0);
  assign enter_acc_c   = in_collect_c && enter_press_c && !clear_press_c && (code_s != 3'd0);
  assign reject_c      = in_collect_c && enter_press_c && !clear_press_c && (code_s == 3'd0)
                         && card_s;

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (card_s) state_nxt = S_COLLECT;
      S_COLLECT: if (enter_acc_c && (digit_count == 2'd2)) state_nxt = S_FULL;
      S_FULL:    if (pin_ready) state_nxt = S_COLLECT;
      default:   state_nxt = S_IDLE;
    endcase
    if (!card_s) state_nxt = S_IDLE;
  end

  // Datapath next values; card removal overrides everything else
  always_comb begin
    d1_nxt      = pin_d1;
    d2_nxt      = pin_d2;
    d3_nxt      = pin_d3;
    dc_nxt      = digit_count;
    tcnt_nxt    = tcnt;
    reject_nxt  = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      S_COLLECT: begin
        reject_nxt = reject_c;
        if (clear_acc_c) begin
          case (digit_count)
            2'd1:    d1_nxt = 3'd0;
            2'd2:    d2_nxt = 3'd0;
            default: d3_nxt = 3'd0;
          endcase
          dc_nxt   = digit_count - 2'd1;
          tcnt_nxt = '0;
        end else if (enter_acc_c) begin
          case (digit_count)
            2'd0:    d1_nxt = code_s;
            2'd1:    d2_nxt = code_s;
            default: d3_nxt = code_s;
          endcase
          dc_nxt   = digit_count + 2'd1;
          tcnt_nxt = '0;
        end else if (digit_count != 2'd0) begin
          if (tcnt == TO_LAST) begin
            d1_nxt      = 3'd0;
            d2_nxt      = 3'd0;
            d3_nxt      = 3'd0;
            dc_nxt      = 2'd0;
            tcnt_nxt    = '0;
            timeout_nxt = 1'b1;
          end else begin
            tcnt_nxt = tcnt + TO_W'(1);
          end
        end else begin
          tcnt_nxt = '0;
        end
      end
      S_FULL: begin
        tcnt_nxt = '0;
        if (pin_ready) begin
          d1_nxt = 3'd0;
          d2_nxt = 3'd0;
          d3_nxt = 3'd0;
          dc_nxt = 2'd0;
        end
      end
      default: begin
        d1_nxt   = 3'd0;
        d2_nxt   = 3'd0;
        d3_nxt   = 3'd0;
        dc_nxt   = 2'd0;
        tcnt_nxt = '0;
      end
    endcase
    if (!card_s) begin
      d1_nxt      = 3'd0;
      d2_nxt      = 3'd0;
      d3_nxt      = 3'd0;
      dc_nxt      = 2'd0;
      tcnt_nxt    = '0;
      reject_nxt  = 1'b0;
      timeout_nxt = 1'b0;
    end
    pin_valid_nxt = (state_nxt == S_FULL);
  end

  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      pin_d1      <= 3'd0;
      pin_d2      <= 3'd0;
      pin_d3      <= 3'd0;
      digit_count <= 2'd0;
      tcnt        <= '0;
      reject      <= 1'b0;
      timeout     <= 1'b0;
      pin_valid   <= 1'b0;
    end else begin
      pin_d1      <= d1_nxt;
      pin_d2      <= d2_nxt;
      pin_d3      <= d3_nxt;
      digit_count <= dc_nxt;
      tcnt        <= tcnt_nxt;
      reject      <= reject_nxt;
      timeout     <= timeout_nxt;
      pin_valid   <= pin_valid_nxt;
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_pin_entry.sv
// Directed bench for pin_entry with DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=20.
module tb_pin_entry;

  logic       clk_2 = 1'b0;
  logic       reset;
  logic       card_in;
  logic       enter_btn;
  logic       clear_btn;
  logic [2:0] code;
  logic       pin_ready;
  logic       pin_valid;
  logic [2:0] pin_d1, pin_d2, pin_d3;
  logic [1:0] digit_count;
  logic       reject;
  logic       timeout;
  logic [1:0] state_out;

  int errors = 0;
  int checks = 0;

  pin_entry #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk_2      (clk_2),
    .reset      (reset),
    .card_in    (card_in),
    .enter_btn  (enter_btn),
    .clear_btn  (clear_btn),
    .code       (code),
    .pin_ready  (pin_ready),
    .pin_valid  (pin_valid),
    .pin_d1     (pin_d1),
    .pin_d2     (pin_d2),
    .pin_d3     (pin_d3),
    .digit_count(digit_count),
    .reject     (reject),
    .timeout    (timeout),
    .state_out  (state_out)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_2);
  endtask

  // Raw press held long enough to be accepted (store visible after the 6th edge)
  task automatic btn_on(input logic en, input logic cl, input logic [2:0] c);
    code      = c;
    enter_btn = en;
    clear_btn = cl;
    cyc(6);
  endtask

  task automatic btn_off();
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    cyc(7);
  endtask

  initial begin
    reset     = 1'b0;
    card_in   = 1'b0;
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    code      = 3'd0;
    pin_ready = 1'b0;
    cyc(2);
    check("rst_state", 16'(state_out), 16'd0);
    check("rst_valid", 16'(pin_valid), 16'd0);
    check("rst_digits", {4'd0, 3'(pin_d1), 3'(pin_d2), 3'(pin_d3), 3'd0}, 16'd0);
    check("rst_count", 16'(digit_count), 16'd0);
    check("rst_pulses", {14'd0, reject, timeout}, 16'd0);
    reset = 1'b1;
    cyc(2);

    // Card in, PIN 1,3,7
    card_in = 1'b1;
    cyc(4);
    check("card_collect", 16'(state_out), 16'd1);
    btn_on(1'b1, 1'b0, 3'd1);
    check("d1_count", 16'(digit_count), 16'd1);
    btn_off();
    btn_on(1'b1, 1'b0, 3'd3);
    btn_off();
    btn_on(1'b1, 1'b0, 3'd7);
    check("full_valid", 16'(pin_valid), 16'd1);
    check("full_state", 16'(state_out), 16'd2);
    check("full_pin", {7'd0, pin_d1, pin_d2, pin_d3}, {7'd0, 3'd1, 3'd3, 3'd7});
    check("full_count", 16'(digit_count), 16'd3);
    btn_off();
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      check("hold_stable", {1'b0, pin_valid, digit_count, 3'd0, pin_d1, pin_d2, pin_d3},
            {1'b0, 1'b1, 2'd3, 3'd0, 3'd1, 3'd3, 3'd7});
    end
    pin_ready = 1'b1;
    cyc(1);
    pin_ready = 1'b0;
    check("hs_valid", 16'(pin_valid), 16'd0);
    check("hs_count", 16'(digit_count), 16'd0);
    check("hs_state", 16'(state_out), 16'd1);
    check("hs_d1", 16'(pin_d1), 16'd0);

    // Bouncing enter, then stable high: one store, 6 edges after stable begins
    code = 3'd2;
    for (int i = 0; i < 10; i++) begin
      enter_btn = (i % 2 == 0);
      cyc(1);
    end
    check("bounce_none", 16'(digit_count), 16'd0);
    enter_btn = 1'b1;
    cyc(5);
    check("bounce_early", 16'(digit_count), 16'd0);
    cyc(1);
    check("bounce_store", 16'(digit_count), 16'd1);
    check("bounce_d1", 16'(pin_d1), 16'd2);
    cyc(14);
    check("bounce_once", 16'(digit_count), 16'd1);
    enter_btn = 1'b0;

    // Inactivity: timeout exactly 20 cycles after the store
    cyc(5);
    check("to_before", {14'd0, timeout, 1'b0}, 16'd0);
    check("to_before_cnt", 16'(digit_count), 16'd1);
    cyc(1);
    check("to_pulse", 16'(timeout), 16'd1);
    check("to_count", 16'(digit_count), 16'd0);
    check("to_d1", 16'(pin_d1), 16'd0);
    check("to_state", 16'(state_out), 16'd1);
    cyc(1);
    check("to_one_cycle", 16'(timeout), 16'd0);
    cyc(4);

    // Zero code rejected; then 5, clear, 6
    btn_on(1'b1, 1'b0, 3'd0);
    check("rej_pulse", 16'(reject), 16'd1);
    check("rej_count", 16'(digit_count), 16'd0);
    cyc(1);
    check("rej_one_cycle", 16'(reject), 16'd0);
    btn_off();
    btn_on(1'b1, 1'b0, 3'd5);
    check("e5_d1", 16'(pin_d1), 16'd5);
    btn_off();
    btn_on(1'b0, 1'b1, 3'd5);
    check("clr_count", 16'(digit_count), 16'd0);
    check("clr_d1", 16'(pin_d1), 16'd0);
    btn_off();
    btn_on(1'b1, 1'b0, 3'd6);
    check("e6_d1", 16'(pin_d1), 16'd6);
    check("e6_count", 16'(digit_count), 16'd1);
    btn_off();

    // Simultaneous enter(4) and clear with two digits stored
    btn_on(1'b1, 1'b0, 3'd1);
    check("two_count", 16'(digit_count), 16'd2);
    btn_off();
    btn_on(1'b1, 1'b1, 3'd4);
    check("sim_count", 16'(digit_count), 16'd1);
    check("sim_d2", 16'(pin_d2), 16'd0);
    check("sim_d1", 16'(pin_d1), 16'd6);
    check("sim_reject", 16'(reject), 16'd0);
    btn_off();
    btn_on(1'b1, 1'b0, 3'd2);
    btn_off();
    btn_on(1'b1, 1'b0, 3'd3);
    check("full2_pin", {6'd0, pin_valid, pin_d1, pin_d2, pin_d3},
          {6'd0, 1'b1, 3'd6, 3'd2, 3'd3});
    btn_off();

    // Card pulled while FULL, with pin_ready sampled on the edge it takes effect
    card_in = 1'b0;
    cyc(2);
    pin_ready = 1'b1;
    cyc(1);
    pin_ready = 1'b0;
    check("pull_state", 16'(state_out), 16'd0);
    check("pull_valid", 16'(pin_valid), 16'd0);
    check("pull_digits", {7'd0, pin_d1, pin_d2, pin_d3}, 16'd0);
    check("pull_count", 16'(digit_count), 16'd0);

    // Reset mid-entry
    card_in = 1'b1;
    cyc(4);
    check("re_card", 16'(state_out), 16'd1);
    btn_on(1'b1, 1'b0, 3'd5);
    check("re_count", 16'(digit_count), 16'd1);
    enter_btn = 1'b0;
    cyc(2);
    #2 reset = 1'b0;
    #1;
    check("arst_state", 16'(state_out), 16'd0);
    check("arst_valid", 16'(pin_valid), 16'd0);
    check("arst_digits", {7'd0, pin_d1, pin_d2, pin_d3}, 16'd0);
    check("arst_count", 16'(digit_count), 16'd0);
    @(negedge clk_2);
    reset = 1'b1;
    cyc(5);
    check("post_state", 16'(state_out), 16'd1);
    check("post_count", 16'(digit_count), 16'd0);
    check("post_d1", 16'(pin_d1), 16'd0);
    check("post_pulses", {14'd0, reject, timeout}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
